// File: rtl/daq_frame_pkg.sv
// Shared types and constants for the DAQ frame builder: FSM states and
// the frame-length helper used to size the byte index.
package daq_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRC_START,
    ST_CRC_WAIT,
    ST_CRC_ACK,
    ST_SEND
  } frame_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // SYNC + SEQ + CRC surround the sample payload.
  localparam int FRAME_OVERHEAD = 3;

  function automatic int frame_bytes(input int data_length);
    return data_length / 8 + FRAME_OVERHEAD;
  endfunction

endpackage

// File: rtl/daq_frame_builder_if.sv
// Sample input, CRC8 handshake and byte-stream output of the frame builder.
// master = frame builder side, slave = the surrounding source/CRC/transmitter.
interface daq_frame_builder_if #(
  parameter int DATA_LENGTH = 32
) ();

  logic [DATA_LENGTH-1:0] s_data;
  logic                   s_valid;
  logic                   s_ready;
  logic [DATA_LENGTH-1:0] crc_data;
  logic                   crc_valid;
  logic                   crc_clear;
  logic [7:0]             crc8_in;
  logic                   crc_ready;
  logic [7:0]             m_byte;
  logic                   m_valid;
  logic                   m_ready;

  modport master (
    input  s_data, s_valid, crc8_in, crc_ready, m_ready,
    output s_ready, crc_data, crc_valid, crc_clear, m_byte, m_valid
  );

  modport slave (
    output s_data, s_valid, crc8_in, crc_ready, m_ready,
    input  s_ready, crc_data, crc_valid, crc_clear, m_byte, m_valid
  );

endinterface

// File: rtl/daq_frame_byte_sel.sv
// Combinational frame byte selector: SYNC, SEQ, payload bytes LSB first, CRC.
module daq_frame_byte_sel #(
  parameter int         DATA_LENGTH = 32,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         FRAME_BYTES = 7,
  parameter int         IDX_W       = 3
) (
  input  logic [IDX_W-1:0]       idx,
  input  logic [7:0]             seq,
  input  logic [DATA_LENGTH-1:0] data,
  input  logic [7:0]             crc,
  output logic [7:0]             byte_out
);

  logic [7:0] frame [FRAME_BYTES];

  assign frame[0]             = SYNC_BYTE;
  assign frame[1]             = seq;
  assign frame[FRAME_BYTES-1] = crc;

  generate
    for (genvar gi = 0; gi < DATA_LENGTH / 8; gi++) begin : g_payload
      assign frame[gi+2] = data[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    byte_out = 8'h00;
    if (int'(idx) < FRAME_BYTES) begin
      byte_out = frame[idx];
    end
  end

endmodule

// File: rtl/daq_frame_builder.sv
// Packetizer: accepts one sample, runs it through the external CRC8 unit,
// then streams SYNC, SEQ, payload and CRC bytes to the link transmitter.
module daq_frame_builder
  import daq_frame_pkg::*;
#(
  parameter int         DATA_LENGTH = 32,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int         CRC_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  daq_frame_builder_if.master bus,
  output logic                busy,
  output logic                crc_timeout
);

  localparam int FRAME_BYTES = frame_bytes(DATA_LENGTH);
  localparam int IDX_W       = $clog2(FRAME_BYTES);
  localparam int TIMER_W     = $clog2(CRC_TIMEOUT);

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(FRAME_BYTES - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(CRC_TIMEOUT - 1);

  frame_state_t           state_reg, state_next;
  logic [DATA_LENGTH-1:0] data_reg, data_next;
  logic [7:0]             crc_reg, crc_next;
  logic [7:0]             seq_reg, seq_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [TIMER_W-1:0]     timer_reg, timer_next;
  logic                   abort_reg, abort_next;
  logic [7:0]             sel_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      data_reg  <= '0;
      crc_reg   <= '0;
      seq_reg   <= '0;
      idx_reg   <= '0;
      timer_reg <= '0;
      abort_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      crc_reg   <= crc_next;
      seq_reg   <= seq_next;
      idx_reg   <= idx_next;
      timer_reg <= timer_next;
      abort_reg <= abort_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    crc_next   = crc_reg;
    seq_next   = seq_reg;
    idx_next   = idx_reg;
    timer_next = timer_reg;
    abort_next = abort_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.s_valid) begin
          data_next  = bus.s_data;
          state_next = ST_CRC_START;
        end
      end

      ST_CRC_START: begin
        timer_next = '0;
        abort_next = 1'b0;
        state_next = ST_CRC_WAIT;
      end

      // A ready arriving on the very cycle the timer expires still wins.
      ST_CRC_WAIT: begin
        timer_next = timer_reg + TIMER_W'(1);
        if (bus.crc_ready) begin
          crc_next   = bus.crc8_in;
          abort_next = 1'b0;
          state_next = ST_CRC_ACK;
        end else if (timer_reg == TIMER_MAX) begin
          abort_next = 1'b1;
          state_next = ST_CRC_ACK;
        end
      end

      ST_CRC_ACK: begin
        idx_next   = '0;
        state_next = abort_reg ? ST_IDLE : ST_SEND;
      end

      ST_SEND: begin
        if (bus.m_ready) begin
          if (idx_reg == LAST_IDX) begin
            idx_next   = '0;
            seq_next   = seq_reg + 8'd1;
            state_next = ST_IDLE;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  daq_frame_byte_sel #(
    .DATA_LENGTH (DATA_LENGTH),
    .SYNC_BYTE   (SYNC_BYTE),
    .FRAME_BYTES (FRAME_BYTES),
    .IDX_W       (IDX_W)
  ) u_byte_sel (
    .idx      (idx_reg),
    .seq      (seq_reg),
    .data     (data_reg),
    .crc      (crc_reg),
    .byte_out (sel_byte)
  );

  // s_ready must drop in the reset cycle itself, not one cycle later.
  assign bus.s_ready   = (state_reg == ST_IDLE) && !reset;
  assign bus.crc_data  = data_reg;
  assign bus.crc_valid = (state_reg == ST_CRC_START);
  assign bus.crc_clear = (state_reg == ST_CRC_ACK);
  assign bus.m_valid   = (state_reg == ST_SEND);
  assign bus.m_byte    = (state_reg == ST_SEND) ? sel_byte : 8'h00;
  assign busy          = (state_reg != ST_IDLE);
  assign crc_timeout   = (state_reg == ST_CRC_ACK) && abort_reg;

endmodule

// File: doc/daq_frame_builder.md
Name: daq_frame_builder

Overview:
Packetizer between the decimated sample source and the byte-serial link transmitter (UART TX). It accepts one DATA_LENGTH-bit sample per handshake and drives the CRC8 unit (data/valid/clear/crc8/ready interface) to obtain the checksum. It then emits the frame SYNC, SEQ, D0..Dn-1 (LSB byte first), CRC as a valid/ready byte stream.

Parameters:
DATA_LENGTH, 32, sample width in bits; multiple of 8, at least 8
SYNC_BYTE, 8'hA5, first byte of every frame
CRC_TIMEOUT, 64, maximum cycles spent in CRC_WAIT before abort; at least 2

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
s_data  input  DATA_LENGTH  sample word
s_valid  input  1  sample valid
s_ready  output  1  block can accept a sample
crc_data  output  DATA_LENGTH  word presented to CRC8 unit (registered copy of the accepted sample)
crc_valid  output  1  start pulse to CRC8 unit
crc_clear  output  1  acknowledge pulse to CRC8 unit
crc8_in  input  8  checksum from CRC8 unit
crc_ready  input  1  checksum valid from CRC8 unit
m_byte  output  8  frame byte to transmitter
m_valid  output  1  m_byte valid
m_ready  input  1  transmitter accepts byte
busy  output  1  high in any state except IDLE
crc_timeout  output  1  one-cycle pulse when a sample is dropped on CRC timeout

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk. All outputs are 0 during and after reset: s_ready, crc_valid, crc_clear, m_valid, busy, crc_timeout, crc_data, m_byte. State = IDLE, seq = 0, byte index = 0, timer = 0. s_ready is forced low in any cycle where reset is high.
- Reset mid-operation aborts the frame immediately. The CRC8 unit shares reset, so no clear is issued.
- FSM states: IDLE, CRC_START, CRC_WAIT, CRC_ACK, SEND.
- IDLE:
  - s_ready=1.
  - On s_valid&&s_ready: latch s_data into data_q and go to CRC_START.
  - crc_data = data_q, held stable from acceptance until the frame leaves CRC_ACK, because CRC8 samples data during calculation.
- CRC_START:
  - crc_valid=1 for exactly this one cycle; timer cleared.
  - Go to CRC_WAIT.
- CRC_WAIT:
  - crc_valid=0; timer increments each cycle.
  - If crc_ready: capture crc8_in into crc_q, go to CRC_ACK (ok).
  - Else if timer == CRC_TIMEOUT-1: go to CRC_ACK (abort).
  - If crc_ready and timeout coincide, crc_ready wins.
- CRC_ACK:
  - crc_clear=1 for exactly one cycle.
  - ok: go to SEND with idx=0.
  - abort: crc_timeout=1 this cycle, sample dropped, seq unchanged, go to IDLE.
- SEND:
  - m_valid=1; m_byte = frame[idx], where frame[0]=SYNC_BYTE, frame[1]=seq, frame[2+k]=data_q[8k+:8], frame[last]=crc_q.
  - FRAME_BYTES = DATA_LENGTH/8 + 3.
  - idx advances only on m_valid&&m_ready.
  - m_byte and m_valid stay stable while m_ready=0; no bubbles between bytes.
  - Accepting the last byte: seq <= seq+1 (wraps 255 -> 0), m_valid=0 next cycle, go to IDLE.
- Throughput:
  - s_ready is 0 from the cycle after acceptance until re-entry to IDLE. No sample buffering; upstream must hold s_valid.
  - Minimum cycles per frame = 3 + CRC latency + FRAME_BYTES.
- crc_ready already high while in CRC_START (stale) is ignored. Only crc_ready seen in CRC_WAIT counts.
- s_valid while busy is ignored (not accepted); s_data changes while busy have no effect.

Decomposition:
- Package daq_frame_pkg holds:
  - the state enum (frame_state_t);
  - SYNC_BYTE default;
  - FRAME_OVERHEAD = 3;
  - a function frame_bytes(DATA_LENGTH).
- One sub-module, daq_frame_byte_sel: a combinational byte selector (idx, seq, data_q, crc_q -> m_byte). The top level holds FSM, timer, seq counter and CRC handshake.

Test Plan:
1. Bench CRC stub returns crc_ready 3 cycles after crc_valid with crc8_in=0x5A; s_data=32'h12345678, m_ready tied 1 -> bytes A5,00,78,56,34,12,5A on consecutive cycles; crc_valid and crc_clear each high exactly 1 cycle; crc_data=12345678 throughout CRC_WAIT.
2. Same stub, m_ready toggling 1-0-1 -> same 7 bytes, no byte skipped or duplicated, m_byte stable while stalled.
3. Stub never asserts crc_ready, CRC_TIMEOUT=64 -> crc_timeout pulses once 64 cycles after CRC_WAIT entry, crc_clear pulses once, no m_valid, next frame's SEQ unchanged.
4. 257 back-to-back frames with real CRC8 instance and reference CRC model -> SEQ runs 00..FF,00; every CRC byte matches the model; s_ready low throughout each frame.
5. Assert reset during SEND byte 3 -> next cycle m_valid=0, s_ready=0 while reset is high, s_ready=1 after release; next frame SEQ=00 and starts with A5.
6. crc_ready forced high in the CRC_START cycle only -> ignored, block stays in CRC_WAIT and completes normally on the real ready.
